// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: blank/show sequencing per digit,
// leading-zero blanking and a shadow buffer committed only at frame wrap.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter bit LZ_SUPPRESS  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    output logic [3:0]              dec_in,
    input  logic [7:0]              dec_seg,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_d;
    logic [7:0]              seg_d;
    logic [NUM_DIGITS-1:0]   digit_en_d;
    logic                    frame_done_d;

    logic                    all_zero;
    logic                    suppress;
    logic [NUM_DIGITS-1:0]   digit_hot;
    logic [7:0]              lit_seg;
    logic [NUM_DIGITS-1:0]   lit_en;

    // Walk from the MSD down so all_zero covers digits N-1..k at step k.
    always_comb begin
        all_zero = 1'b1;
        dec_in   = 4'h0;
        suppress = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (display_q[4*k +: 4] == 4'h0);
            if (idx_q == IW'(k)) begin
                dec_in   = display_q[4*k +: 4];
                suppress = LZ_SUPPRESS && (k != 0) && all_zero;
            end
        end
    end

    assign digit_hot = NUM_DIGITS'(1) << idx_q;
    assign lit_seg   = suppress ? 8'h00 : dec_seg;
    assign lit_en    = suppress ? '0 : digit_hot;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        display_d    = display_q;
        shadow_d     = shadow_q;
        pending_d    = pending;
        seg_d        = seg_out;
        digit_en_d   = digit_en;
        frame_done_d = 1'b0;

        unique case (state_q)
            S_OFF: begin
                seg_d      = 8'h00;
                digit_en_d = '0;
                idx_d      = '0;
                cnt_d      = '0;
                // Fresh data written while dark is newer than any staged copy.
                if (load) begin
                    display_d = data_in;
                    pending_d = 1'b0;
                end else if (enable && pending) begin
                    display_d = shadow_q;
                    pending_d = 1'b0;
                end
                if (enable) begin
                    state_d = S_BLANK;
                end
            end

            S_BLANK, S_SHOW: begin
                if (load) begin
                    shadow_d  = data_in;
                    pending_d = 1'b1;
                end
                if (!enable) begin
                    state_d    = S_OFF;
                    idx_d      = '0;
                    cnt_d      = '0;
                    seg_d      = 8'h00;
                    digit_en_d = '0;
                end else if (state_q == S_BLANK) begin
                    seg_d      = 8'h00;
                    digit_en_d = '0;
                    if (cnt_q == BLANK_LAST) begin
                        state_d    = S_SHOW;
                        cnt_d      = '0;
                        seg_d      = lit_seg;
                        digit_en_d = lit_en;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == SHOW_LAST) begin
                    state_d    = S_BLANK;
                    cnt_d      = '0;
                    seg_d      = 8'h00;
                    digit_en_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        // A load on this same edge stays staged for next frame.
                        if (pending) begin
                            display_d = shadow_q;
                            pending_d = load;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    seg_d = lit_seg;
                end
            end

            default: begin
                state_d    = S_OFF;
                seg_d      = 8'h00;
                digit_en_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_OFF;
            idx_q      <= '0;
            cnt_q      <= '0;
            display_q  <= '0;
            shadow_q   <= '0;
            pending    <= 1'b0;
            seg_out    <= 8'h00;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            display_q  <= display_d;
            shadow_q   <= shadow_d;
            pending    <= pending_d;
            seg_out    <= seg_d;
            digit_en   <= digit_en_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model feeding a
// scoreboard queue, scripted scenarios followed by random traffic.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int B     = 2;
    localparam int SLOT  = B + P;
    localparam int FRAME = N * SLOT;
    localparam bit LZ    = 1'b1;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dec_in;
    logic [7:0]  dec_seg;
    logic [7:0]  seg_out;
    logic [3:0]  digit_en;
    logic        frame_done;
    logic        pending;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .PRESCALE    (P),
        .BLANK_CYCLES(B),
        .LZ_SUPPRESS (LZ)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .enable    (enable),
        .load      (load),
        .data_in   (data_in),
        .dec_in    (dec_in),
        .dec_seg   (dec_seg),
        .seg_out   (seg_out),
        .digit_en  (digit_en),
        .frame_done(frame_done),
        .pending   (pending)
    );

    // Board decoder stand-in; codes above 9 come back dark.
    function automatic logic [7:0] seg_lut(input logic [3:0] c);
        case (c)
            4'd0: return 8'b00111111;
            4'd1: return 8'b00000001;
            4'd2: return 8'b01000001;
            4'd3: return 8'b01001001;
            4'd4: return 8'b01100010;
            4'd5: return 8'b01011010;
            4'd6: return 8'b01111010;
            4'd7: return 8'b01100100;
            4'd8: return 8'b00110110;
            4'd9: return 8'b01101110;
            default: return 8'h00;
        endcase
    endfunction

    assign dec_seg = seg_lut(dec_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [13:0] exp_q[$];
    logic [13:0] mon_exp;

    // Reference model: position within the frame since scanning began.
    bit          mrun;
    int          mt;
    logic [15:0] mdisp;
    logic [15:0] mshadow;
    bit          mpend;
    bit          mfd;
    bit          hold_rst;

    function automatic void chk(input string name, input logic [13:0] act,
                                input logic [13:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got seg=%b en=%b fd=%b pend=%b, want seg=%b en=%b fd=%b pend=%b",
                     name, $time, act[13:6], act[5:2], act[1], act[0],
                     exp[13:6], exp[5:2], exp[1], exp[0]);
        end
    endfunction

    function automatic logic [13:0] expect_out();
        logic [7:0] s;
        logic [3:0] en;
        int         d;
        int         ph;
        s  = 8'h00;
        en = 4'h0;
        if (mrun) begin
            d  = mt / SLOT;
            ph = mt % SLOT;
            if (ph >= B && !(LZ && d > 0 && (mdisp >> (4 * d)) == 16'h0)) begin
                s  = seg_lut(mdisp[4*d +: 4]);
                en = 4'(1 << d);
            end
        end
        return {s, en, mfd, mpend};
    endfunction

    function automatic void model_clear();
        mrun    = 1'b0;
        mt      = 0;
        mdisp   = 16'h0;
        mshadow = 16'h0;
        mpend   = 1'b0;
        mfd     = 1'b0;
    endfunction

    function automatic void model_edge();
        mfd = 1'b0;
        if (rst) begin
            model_clear();
        end else if (mrun) begin
            if (!enable) begin
                mrun = 1'b0;
                mt   = 0;
            end else begin
                mt++;
                if (mt == FRAME) begin
                    mt  = 0;
                    mfd = 1'b1;
                    if (mpend) begin
                        mdisp = mshadow;
                        mpend = 1'b0;
                    end
                end
            end
            if (load) begin
                mshadow = data_in;
                mpend   = 1'b1;
            end
        end else begin
            if (load) begin
                mdisp = data_in;
                mpend = 1'b0;
            end else if (enable && mpend) begin
                mdisp = mshadow;
                mpend = 1'b0;
            end
            if (enable) begin
                mrun = 1'b1;
                mt   = 0;
            end
        end
    endfunction

    task automatic step(input bit en, input bit ld, input logic [15:0] d);
        @(negedge clk);
        rst     = hold_rst;
        enable  = en;
        load    = ld;
        data_in = d;
        @(posedge clk);
        model_edge();
        exp_q.push_back(expect_out());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0);
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (mt != target || !mrun) begin
            if (guard > 2 * FRAME) begin
                n_checks++;
                $display("FAIL run_until t=%0t: position %0d never reached (at %0d)",
                         $time, target, mt);
                return;
            end
            step(1'b1, 1'b0, 16'h0);
            guard++;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        hold_rst = 1'b1;
        #1 chk("async_reset", {seg_out, digit_en, frame_done, pending}, 14'h0);
        model_clear();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            chk("cycle", {seg_out, digit_en, frame_done, pending}, mon_exp);
        end
    end

    initial begin
        logic [15:0] rv;
        int          lead;
        bit          ren;
        bit          rld;

        rst      = 1'b1;
        hold_rst = 1'b1;
        enable   = 1'b1;
        load     = 1'b0;
        data_in  = 16'h0;
        model_clear();

        #1 chk("reset_state", {seg_out, digit_en, frame_done, pending}, 14'h0);
        repeat (3) step(1'b1, 1'b0, 16'h0);

        hold_rst = 1'b0;
        step(1'b0, 1'b1, 16'h1234);
        step(1'b0, 1'b0, 16'h0);
        run(2 * FRAME + 12);

        run_until(SLOT + B + 1);
        step(1'b1, 1'b1, 16'h5678);
        run_until(FRAME - 1);
        run(SLOT + 2);

        step(1'b1, 1'b1, 16'h0007);
        run_until(FRAME - 1);
        run(FRAME + 2);
        step(1'b1, 1'b1, 16'h0000);
        run_until(FRAME - 1);
        run(FRAME + 2);
        step(1'b1, 1'b1, 16'h0A00);
        run_until(FRAME - 1);
        run(FRAME + 2);

        step(1'b1, 1'b1, 16'h1111);
        run(3);
        step(1'b1, 1'b1, 16'h2222);
        run_until(FRAME - 1);
        step(1'b1, 1'b1, 16'h3333);
        run(FRAME - 1);
        run_until(FRAME - 1);
        run(SLOT + 2);

        run_until(2 * SLOT + B + 1);
        step(1'b0, 1'b0, 16'h0);
        repeat (3) step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        run(FRAME + 4);

        run_until(B + 1);
        async_reset();
        repeat (2) step(1'b1, 1'b0, 16'h0);
        hold_rst = 1'b0;
        step(1'b0, 1'b1, 16'h9087);
        step(1'b1, 1'b0, 16'h0);
        run(FRAME);

        for (int i = 0; i < 900; i++) begin
            ren  = ($urandom_range(0, 99) < 97);
            rld  = ($urandom_range(0, 19) == 0);
            rv   = 16'($urandom);
            lead = $urandom_range(0, 4);
            if (lead > 0) rv = rv & (16'hFFFF >> (4 * lead));
            step(ren, rld, rv);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display.
- Sequences the shared seg decoder (4-bit code in, 8-bit pattern out, combinational) across NUM_DIGITS digit positions.
- Drives one-hot digit enables with a blanking interval between digits, and double-buffers display data so updates never tear mid-frame.
- Sits between the value producer (counter/ALU logic) and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8); digit NUM_DIGITS-1 is most significant.
- PRESCALE, 1000, clock cycles each digit is shown (>=1).
- BLANK_CYCLES, 16, dark cycles before each digit (>=1).
- LZ_SUPPRESS, 1, 1 = blank leading zero digits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = scanning; 0 = display off.
- load  input  1  one-cycle strobe that captures data_in.
- data_in  input  4*NUM_DIGITS  packed digit codes, digit k at [4k+3:4k].
- dec_in  output  4  code presented to seg decoder `in` (combinational from display[idx]).
- dec_seg  input  8  pattern returned from seg decoder `out`.
- seg_out  output  8  registered segment pattern to pins.
- digit_en  output  NUM_DIGITS  registered one-hot digit enable, active-high.
- frame_done  output  1  one-cycle pulse at frame wrap.
- pending  output  1  shadow holds data not yet committed.

Behaviour:
- Reset (async):
  - State OFF; idx=0; counter=0; display=0; shadow=0.
  - seg_out=0, digit_en=0, frame_done=0, pending=0.
- Registers: display (shown), shadow (staged), 2-bit state {OFF, BLANK, SHOW}, idx, cycle counter.
- OFF:
  - Outputs 0. enable=1 -> BLANK with idx=0, counter=0 on the next edge.
  - load in OFF writes data_in directly to display; pending stays 0.
- BLANK:
  - digit_en=0, seg_out=0. Lasts exactly BLANK_CYCLES cycles, then SHOW.
  - On that edge: digit_en<=one-hot(idx) and seg_out<=dec_seg, or 0 if the digit is suppressed.
- SHOW:
  - Lasts exactly PRESCALE cycles. seg_out tracks dec_seg each cycle (1-cycle register delay).
  - Then BLANK with idx<=(idx+1) mod NUM_DIGITS, digit_en<=0, seg_out<=0.
- Frame wrap (SHOW->BLANK with idx NUM_DIGITS-1 -> 0):
  - frame_done=1 for that one cycle.
  - If pending: display<=shadow and pending<=0.
  - Frame length = NUM_DIGITS*(BLANK_CYCLES+PRESCALE) cycles.
- load while scanning:
  - shadow<=data_in, pending<=1. A second load before commit overwrites shadow (last wins).
  - load on the commit edge: display takes the old shadow, shadow takes new data_in, pending stays 1.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit idx>0 is suppressed if display digits NUM_DIGITS-1..idx are all 4'h0.
  - A suppressed digit keeps its SHOW time but digit_en=0 and seg_out=0.
  - Digit 0 is never suppressed.
- Codes >9 are passed through unchanged; the decoder returns 8'h00 (digit dark but enabled).
- enable falling in BLANK/SHOW: OFF on the next edge; outputs 0, idx/counter cleared, no frame_done, pending/shadow retained.
- enable rising again: scan restarts at idx 0. If pending, display<=shadow on the OFF->BLANK edge.
- reset mid-operation: all outputs 0 immediately (asynchronous), state OFF.

Test Plan:
- Use PRESCALE=4, BLANK_CYCLES=2, NUM_DIGITS=4, LZ_SUPPRESS=1.
- Reset with enable=1 -> seg_out=8'h00, digit_en=4'b0000, pending=0 while reset is high.
- Reset released; load data_in=16'h1234 in OFF, then enable -> 2 dark cycles, digit_en=0001 with seg_out=01100010 for 4 cycles. Then 2 dark cycles, 0010/01001001, 0100/01000001, 1000/00000001. frame_done pulses every 24 cycles.
- Mid-frame load 16'h5678 -> pending=1, digits continue showing 1234 values. At wrap, pending=0 and the next digit 0 shows 00110110.
- Load 16'h0007 -> digits 3..1 give digit_en=0 for their SHOW windows; digit 0 shows 01100100. Load 16'h0000 -> only digit 0 lit, 00111111. Load 16'h0A00 -> digit 2 enabled with seg_out=00000000.
- Two loads 16'h1111 then 16'h2222 before wrap, plus a load coinciding with the wrap edge -> display takes 2222, then the coinciding value one frame later.
- enable=0 mid-SHOW of digit 2 -> OFF next edge, outputs 0, no frame_done. Re-enable -> restarts at digit 0 after 2 blank cycles. Async reset pulse mid-SHOW -> outputs 0 within the same cycle.
